// File: rtl/aes_inv_key_schedule.sv
// Reverse AES-128 key schedule: loads the round-10 key and streams round keys 10..0 over valid/ready.
// One key per accepted transfer; all outputs registered, S-box computed as GF(2^8) inverse + affine.
module aes_inv_key_schedule (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] last_key,
  input  logic         key_ready,
  output logic         key_valid,
  output logic [127:0] round_key,
  output logic [3:0]   round_num,
  output logic         busy,
  output logic         done
);

  typedef enum logic {IDLE, SEND} state_t;
  state_t state;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // x^254 = product of x^(2^k) for k=1..7; maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] r;
    p = gf_mul(x, x);
    r = p;
    for (int k = 2; k < 8; k++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  logic [31:0]  a0, a1, a2, a3;
  logic [31:0]  b0, b1, b2, b3;
  logic [127:0] next_key;
  logic         xfer;

  // round_num holds r+1 while deriving K(r), so it indexes Rcon directly.
  always_comb begin
    {a0, a1, a2, a3} = round_key;
    b3 = a3 ^ a2;
    b2 = a2 ^ a1;
    b1 = a1 ^ a0;
    b0 = a0 ^ sub_word({b3[23:0], b3[31:24]}) ^ {rcon(round_num), 24'h0};
    next_key = {b0, b1, b2, b3};
  end

  assign xfer = key_valid & key_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      key_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      round_num <= 4'd0;
      round_key <= 128'h0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= SEND;
            key_valid <= 1'b1;
            busy      <= 1'b1;
            round_num <= 4'd10;
            round_key <= last_key;
          end
        end
        SEND: begin
          if (xfer) begin
            if (round_num == 4'd0) begin
              state     <= IDLE;
              key_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              round_num <= round_num - 4'd1;
              round_key <= next_key;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Bench for aes_inv_key_schedule: word-array reverse key schedule model, FIPS-197 vectors,
// random backpressure, ignored starts, async reset mid-sequence and back-to-back restart.
module tb_aes_inv_key_schedule;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [127:0] last_key;
  logic         key_ready;
  logic         key_valid;
  logic [127:0] round_key;
  logic [3:0]   round_num;
  logic         busy;
  logic         done;

  aes_inv_key_schedule dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .last_key  (last_key),
    .key_ready (key_ready),
    .key_valid (key_valid),
    .round_key (round_key),
    .round_num (round_num),
    .busy      (busy),
    .done      (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_err = 0;
  int last_cyc;
  logic [127:0] exp_k [0:10];
  logic [127:0] obs   [0:10];

  localparam logic [127:0] FIPS_LAST = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] FIPS_R9   = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] FIPS_R1   = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_R0   = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Carry-less multiply then reduce modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] m_sbox(input logic [7:0] x);
    logic [7:0] inv, s, c;
    inv = 8'h00;
    c   = 8'h63;
    for (int y = 1; y < 256; y++) if (m_mul(x, 8'(y)) == 8'h01) inv = 8'(y);
    for (int i = 0; i < 8; i++)
      s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
    return s;
  endfunction

  function automatic logic [7:0] m_rcon(input int idx);
    logic [7:0] rc;
    rc = 8'h01;
    for (int k = 1; k < idx; k++) rc = m_mul(rc, 8'h02);
    return rc;
  endfunction

  // Undo w[i] = w[i-4] ^ temp over the 44-word expanded key, from w43 down to w0.
  task automatic ref_model(input logic [127:0] lk);
    logic [31:0] w [0:43];
    logic [31:0] t;
    {w[40], w[41], w[42], w[43]} = lk;
    for (int i = 43; i >= 4; i--) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {m_sbox(t[31:24]), m_sbox(t[23:16]), m_sbox(t[15:8]), m_sbox(t[7:0])};
        t = t ^ {m_rcon(i / 4), 24'h0};
      end
      w[i-4] = w[i] ^ t;
    end
    for (int r = 0; r <= 10; r++) exp_k[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic start_seq(input logic [127:0] lk);
    start    = 1'b1;
    last_key = lk;
    @(negedge clk);
    start    = 1'b0;
    last_key = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic drain(input logic [127:0] lk, input int pct, input int inj_round,
                       input int rst_round, input bit start_at_end, input logic [127:0] next_lk);
    int e;
    int cyc;
    ref_model(lk);
    e   = 10;
    cyc = 0;
    while (e >= 0 && cyc < 300) begin
      start = 1'b0;
      if (!key_valid) begin
        check("key_valid_mid", key_valid, 1);
        key_ready = 1'b0;
        return;
      end
      check("round_num", round_num, e);
      check("round_key", round_key, exp_k[e]);
      check("busy_mid", busy, 1);
      obs[e] = round_key;
      if (rst_round == e) begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid", key_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_round_num", round_num, 0);
        key_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (inj_round == e) begin
        start    = 1'b1;
        last_key = ~lk;
      end
      key_ready = ($urandom_range(99) < pct);
      if (key_ready) begin
        if (e == 0 && start_at_end) begin
          start    = 1'b1;
          last_key = next_lk;
        end
        e--;
      end
      cyc++;
      @(negedge clk);
    end
    last_cyc  = cyc;
    key_ready = 1'b0;
    if (e >= 0) begin
      check("timeout", 0, 1);
      return;
    end
    check("end_valid", key_valid, 0);
    check("end_busy", busy, 0);
    check("end_done", done, 1);
    check("end_round_num", round_num, 0);
    check("end_round_key", round_key, exp_k[0]);
    if (start_at_end) begin
      start    = 1'b1;
      last_key = next_lk;
      @(negedge clk);
      start    = 1'b0;
      last_key = {$urandom, $urandom, $urandom, $urandom};
    end else begin
      start = 1'b0;
      @(negedge clk);
      check("done_once", done, 0);
      check("idle_valid", key_valid, 0);
      check("idle_busy", busy, 0);
    end
  endtask

  initial begin
    logic [127:0] k1, k2;
    rst_n     = 1'b0;
    start     = 1'b0;
    key_ready = 1'b0;
    last_key  = '0;
    #12;
    check("reset_valid", key_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_round_num", round_num, 0);
    check("reset_round_key", round_key, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // full-rate FIPS-197 sequence
    start_seq(FIPS_LAST);
    drain(FIPS_LAST, 100, -1, -1, 0, '0);
    check("full_rate_cycles", last_cyc, 11);
    check("fips_r10", obs[10], FIPS_LAST);
    check("fips_r9", obs[9], FIPS_R9);
    check("fips_r1", obs[1], FIPS_R1);
    check("fips_r0", obs[0], FIPS_R0);

    // random backpressure
    start_seq(FIPS_LAST);
    drain(FIPS_LAST, 50, -1, -1, 0, '0);

    // start while busy is ignored
    start_seq(FIPS_LAST);
    drain(FIPS_LAST, 70, 5, -1, 0, '0);
    check("inj_r0", obs[0], FIPS_R0);

    // async reset mid-sequence, then a clean restart
    start_seq(FIPS_LAST);
    drain(FIPS_LAST, 80, -1, 3, 0, '0);
    check("post_rst_valid", key_valid, 0);
    start_seq(FIPS_LAST);
    drain(FIPS_LAST, 100, -1, -1, 0, '0);

    // start coinciding with the final transfer is dropped, next cycle's start is taken
    k1 = {$urandom, $urandom, $urandom, $urandom};
    k2 = {$urandom, $urandom, $urandom, $urandom};
    start_seq(k1);
    drain(k1, 60, -1, -1, 1, k2);
    drain(k2, 60, -1, -1, 0, '0);

    // all-zero final key
    start_seq('0);
    drain('0, 60, -1, -1, 0, '0);

    for (int n = 0; n < 4; n++) begin
      k1 = {$urandom, $urandom, $urandom, $urandom};
      start_seq(k1);
      drain(k1, int'($urandom_range(30, 100)), -1, -1, 0, '0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
